// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and data access.
// Data has priority over fetch, but a run limit stops data from starving fetch. An ack timeout aborts a transaction the memory never completes.
module mem_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int TIMEOUT   = 16,
    parameter int MAX_D_RUN = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,

    output logic          err,
    output logic          err_sticky,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_D_RUN + 1);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_D_RUN);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner_d;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] run_cnt;
    logic          abort_q;
    logic          grant_d, grant_if;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // When fetch is also waiting, data wins only until it has used up its run of contested grants.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        mem_req   = 1'b0;
        if_valid  = 1'b0;
        d_valid   = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || run_cnt != RUN_MAX)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                if (mem_ack || tcnt == TMAX)
                    state_nxt = RESP;
            end
            RESP: begin
                if_valid  = !owner_d;
                d_valid   = owner_d;
                err       = abort_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_we    = (state == BUSY) & we_q;
    assign mem_addr  = (state == BUSY) ? addr_q  : '0;
    assign mem_wdata = (state == BUSY) ? wdata_q : '0;

    // An ack on the last allowed BUSY cycle still counts as success.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_d    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            tcnt       <= '0;
            run_cnt    <= '0;
            abort_q    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (grant_d || grant_if) begin
                owner_d <= grant_d;
                addr_q  <= grant_d ? d_addr : if_addr;
                we_q    <= grant_d & d_we;
                wdata_q <= grant_d ? d_wdata : '0;
                abort_q <= 1'b0;
                tcnt    <= '0;
                if (grant_if || !if_req)
                    run_cnt <= '0;
                else if (run_cnt != RUN_MAX)
                    run_cnt <= run_cnt + RW'(1);
            end

            if (state == BUSY) begin
                tcnt <= tcnt + TW'(1);
                if (mem_ack) begin
                    if (!owner_d)
                        if_rdata <= mem_rdata;
                    else if (!we_q)
                        d_rdata <= mem_rdata;
                end else if (tcnt == TMAX) begin
                    abort_q    <= 1'b1;
                    err_sticky <= 1'b1;
                    if (owner_d)
                        d_rdata <= '0;
                    else
                        if_rdata <= '0;
                end
            end

            if (state == RESP)
                tcnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: cycle vectors from a table plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        err;
    logic        err_sticky;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.DW(32), .AW(32), .TIMEOUT(16), .MAX_D_RUN(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .err(err), .err_sticky(err_sticky),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        x_mem_req;
        logic        x_mem_we;
        logic [31:0] x_mem_addr;
        logic [31:0] x_mem_wdata;
        logic        x_if_valid;
        logic [31:0] x_if_rdata;
        logic        x_d_valid;
        logic [31:0] x_d_rdata;
        logic        x_err;
        logic        x_err_sticky;
    } vec_t;

    localparam logic [31:0] RD1 = 32'h8C220004;
    localparam logic [31:0] SWD = 32'hCAFEF00D;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        d_req     = v.d_req;
        d_we      = v.d_we;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        mem_ack   = v.mem_ack;
        mem_rdata = v.mem_rdata;
    endtask

    task automatic checkVector(input int i, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", i);
        checkOutput({tag, "_mem_req"},    {31'b0, mem_req},    {31'b0, v.x_mem_req});
        checkOutput({tag, "_mem_we"},     {31'b0, mem_we},     {31'b0, v.x_mem_we});
        checkOutput({tag, "_mem_addr"},   mem_addr,            v.x_mem_addr);
        checkOutput({tag, "_mem_wdata"},  mem_wdata,           v.x_mem_wdata);
        checkOutput({tag, "_if_valid"},   {31'b0, if_valid},   {31'b0, v.x_if_valid});
        checkOutput({tag, "_if_rdata"},   if_rdata,            v.x_if_rdata);
        checkOutput({tag, "_d_valid"},    {31'b0, d_valid},    {31'b0, v.x_d_valid});
        checkOutput({tag, "_d_rdata"},    d_rdata,             v.x_d_rdata);
        checkOutput({tag, "_err"},        {31'b0, err},        {31'b0, v.x_err});
        checkOutput({tag, "_err_sticky"}, {31'b0, err_sticky}, {31'b0, v.x_err_sticky});
    endtask

    // Waits up to a bounded number of cycles for mem_req; an expired bound is a failed check.
    task automatic waitBusy(input string name);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (mem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no mem_req within %0d cycles, required mem_req=1", name, n);
        end
    endtask

    initial begin
        int dcount;
        int n;
        logic exp_data;
        logic [31:0] exp_addr;

        // Test 1 (fetch, zero wait, stray ack) then test 3 (store with 3 wait cycles).
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, RD1,          1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 1'b1, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,   32'h0, 1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40, SWD,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40, SWD,   1'b0, 32'h0,        1'b1, 1'b1, 32'h40,  SWD,   1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40, SWD,   1'b0, 32'h0,        1'b1, 1'b1, 32'h40,  SWD,   1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40, SWD,   1'b0, 32'h0,        1'b1, 1'b1, 32'h40,  SWD,   1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40, SWD,   1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'h40,  SWD,   1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40, SWD,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 1'b0, RD1,   1'b1, 32'h0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 1'b0, RD1,   1'b0, 32'h0, 1'b0, 1'b0};

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] table vectors: fetch and wait-state store");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
            tick();
        end

        $display("[TB] simultaneous fetch and load");
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick();
        checkOutput("both_first_addr", mem_addr, 32'h2000);
        checkOutput("both_first_we", {31'b0, mem_we}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_ack = 1'b0;
        checkOutput("both_d_valid", {31'b0, d_valid}, 32'h1);
        checkOutput("both_d_rdata", d_rdata, 32'h11112222);
        checkOutput("both_if_not_yet", {31'b0, if_valid}, 32'h0);
        d_req = 1'b0;
        tick();
        checkOutput("both_idle_gap", {31'b0, mem_req}, 32'h0);
        tick();
        checkOutput("both_fetch_addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'h33334444;
        tick();
        mem_ack = 1'b0;
        checkOutput("both_if_valid", {31'b0, if_valid}, 32'h1);
        checkOutput("both_if_rdata", if_rdata, 32'h33334444);
        checkOutput("both_no_d_valid", {31'b0, d_valid}, 32'h0);
        if_req = 1'b0;
        tick();

        $display("[TB] starvation limit");
        dcount = 0;
        if_req = 1'b1; if_addr = 32'h500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
        for (int g = 0; g < 10; g++) begin
            waitBusy("starve_wait");
            exp_data = ((g % 5) != 4);
            exp_addr = exp_data ? 32'h1000 + 32'(dcount * 4) : 32'h500;
            checkOutput($sformatf("starve_grant%0d", g), mem_addr, exp_addr);
            mem_ack = 1'b1; mem_rdata = 32'h77000000 + 32'(g);
            tick();
            mem_ack = 1'b0;
            checkOutput($sformatf("starve_valid%0d", g),
                        {31'b0, exp_data ? d_valid : if_valid}, 32'h1);
            if (exp_data) begin
                dcount++;
                d_addr = 32'h1000 + 32'(dcount * 4);
            end
            tick();
        end
        d_req = 1'b0; if_req = 1'b0;
        tick();
        tick();
        checkOutput("starve_done_idle", {31'b0, mem_req}, 32'h0);

        $display("[TB] ack timeout");
        checkOutput("tmo_sticky_before", {31'b0, err_sticky}, 32'h0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        tick();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checkOutput("tmo_busy_cycles", 32'(n), 32'd16);
        checkOutput("tmo_d_valid", {31'b0, d_valid}, 32'h1);
        checkOutput("tmo_err", {31'b0, err}, 32'h1);
        checkOutput("tmo_d_rdata", d_rdata, 32'h0);
        checkOutput("tmo_sticky", {31'b0, err_sticky}, 32'h1);
        d_req = 1'b0;
        tick();
        checkOutput("tmo_err_pulse_end", {31'b0, err}, 32'h0);
        checkOutput("tmo_valid_pulse_end", {31'b0, d_valid}, 32'h0);
        checkOutput("tmo_sticky_holds", {31'b0, err_sticky}, 32'h1);

        $display("[TB] ack on the last allowed cycle");
        d_req = 1'b1; d_addr = 32'h64;
        tick();
        for (int k = 0; k < 15; k++) tick();
        checkOutput("late_still_busy", {31'b0, mem_req}, 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'hABCD0123;
        tick();
        mem_ack = 1'b0;
        checkOutput("late_d_valid", {31'b0, d_valid}, 32'h1);
        checkOutput("late_no_err", {31'b0, err}, 32'h0);
        checkOutput("late_d_rdata", d_rdata, 32'hABCD0123);
        d_req = 1'b0;
        tick();

        $display("[TB] reset mid-transaction");
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        tick();
        checkOutput("rst_second_busy", {31'b0, mem_req}, 32'h1);
        reset = 1'b1; if_req = 1'b0;
        tick();
        reset = 1'b0;
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst_sticky_clear", {31'b0, err_sticky}, 32'h0);
        checkOutput("rst_d_rdata", d_rdata, 32'h0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rst_no_valid%0d", k), {31'b0, if_valid}, 32'h0);
            tick();
        end
        if_req = 1'b1; if_addr = 32'h704;
        tick();
        checkOutput("rst_after_addr", mem_addr, 32'h704);
        mem_ack = 1'b1; mem_rdata = 32'h0BADCAFE;
        tick();
        mem_ack = 1'b0;
        checkOutput("rst_after_valid", {31'b0, if_valid}, 32'h1);
        checkOutput("rst_after_rdata", if_rdata, 32'h0BADCAFE);
        if_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
